// File: rtl/param_serializer.sv
`default_nettype none
// ============================================================================
// Module      : param_serializer
// Description : Parametrised parallel-to-serial converter for the UART TX
//               datapath. Loads a DATA_WIDTH-bit word, emits it one bit per
//               baud tick (shift_en) in LSB- or MSB-first order, flags the
//               end of each word with a one-cycle ser_done pulse and keeps
//               the even-parity bit of the loaded word for the parity stage.
//               A new word may be loaded on the completion edge of the
//               previous one, giving gap-free back-to-back transmission.
// Ports       : CLK      - system clock, rising edge
//               RST      - synchronous active-low reset
//               P_DATA   - parallel word, sampled only on a load edge
//               ser_en   - load strobe
//               shift_en - advance enable (baud tick)
//               ser_data - registered serial bit
//               ser_done - one-cycle pulse after the last bit period
//               busy     - high while a word is being shifted
//               par_bit  - XOR of the loaded word, held until next load
// Revision    : 1.0 - initial release
// ============================================================================
module param_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  ser_en,
  input  logic                  shift_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  busy,
  output logic                  par_bit
);

  localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_par;
  logic                  w_par_nxt;
  logic                  w_load;

  // The outgoing bit always sits at the exit end of the shift register, so
  // ser_data comes straight from a flop. Clearing the register on completion
  // returns ser_data to 0 without a separate output flop.
  logic [DATA_WIDTH-1:0] w_shifted;
  logic                  w_out_bit;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_shift[DATA_WIDTH-2:0], 1'b0};
      assign w_out_bit = r_shift[DATA_WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, r_shift[DATA_WIDTH-1:1]};
      assign w_out_bit = r_shift[0];
    end
  endgenerate

  // State register and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_par   <= w_par_nxt;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_par_nxt   = r_par;
    w_load      = 1'b0;

    case (r_state)
      IDLE: begin
        if (ser_en) begin
          w_load = 1'b1;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (r_cnt == LAST_CNT) begin
            w_done_nxt = 1'b1;
            // ser_en is only honoured here while busy: back-to-back reload.
            if (ser_en) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_shift_nxt = '0;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_shift_nxt = w_shifted;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_load) begin
      w_state_nxt = SHIFT;
      w_shift_nxt = P_DATA;
      w_cnt_nxt   = '0;
      w_par_nxt   = ^P_DATA;
    end
  end

  assign ser_data = w_out_bit;
  assign ser_done = r_done;
  assign busy     = (r_state == SHIFT);
  assign par_bit  = r_par;

endmodule
`default_nettype wire

// File: tb/tb_param_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_serializer
// Description : Self-checking bench for param_serializer. Three instances:
//               8-bit LSB-first, 8-bit MSB-first and 12-bit LSB-first.
//               Stimulus pushes the expected per-cycle outputs into a queue
//               per instance; a monitor pops and compares on each falling
//               edge. Expected bit orders are hand-written strings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_serializer;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  en;
  logic [2:0]  sh;
  logic [31:0] pdata;

  logic [2:0]  sd;
  logic [2:0]  dn;
  logic [2:0]  bz;
  logic [2:0]  pb;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic sd;
    logic bz;
    logic dn;
    logic pb;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
    .CLK(clk), .RST(rst[0]), .P_DATA(pdata[7:0]), .ser_en(en[0]), .shift_en(sh[0]),
    .ser_data(sd[0]), .ser_done(dn[0]), .busy(bz[0]), .par_bit(pb[0])
  );

  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
    .CLK(clk), .RST(rst[1]), .P_DATA(pdata[7:0]), .ser_en(en[1]), .shift_en(sh[1]),
    .ser_data(sd[1]), .ser_done(dn[1]), .busy(bz[1]), .par_bit(pb[1])
  );

  param_serializer #(.DATA_WIDTH(12), .MSB_FIRST(1'b0)) u_lsb12 (
    .CLK(clk), .RST(rst[2]), .P_DATA(pdata[11:0]), .ser_en(en[2]), .shift_en(sh[2]),
    .ser_data(sd[2]), .ser_done(dn[2]), .busy(bz[2]), .par_bit(pb[2])
  );

  function automatic exp_t mk(input logic s, input logic b, input logic d, input logic p);
    exp_t e;
    e.sd = s;
    e.bz = b;
    e.dn = d;
    e.pb = p;
    return e;
  endfunction

  function automatic logic sbit(input string s, input int k);
    return (s[k] == "1");
  endfunction

  task automatic cmp(input string name, input int ch, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s ch%0d t=%0t: got %b expected %b", name, ch, $time, act, exp_v);
    end
  endtask

  task automatic check_ch(input int ch, input exp_t e);
    cmp("ser_data", ch, sd[ch], e.sd);
    cmp("busy",     ch, bz[ch], e.bz);
    cmp("ser_done", ch, dn[ch], e.dn);
    cmp("par_bit",  ch, pb[ch], e.pb);
  endtask

  // Monitor: one expectation per cycle per instance, popped mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check_ch(0, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check_ch(1, e);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      check_ch(2, e);
    end
  end

  // One clock edge; e is the expected output in the cycle after that edge.
  task automatic cyc(input int ch, input exp_t e);
    @(posedge clk);
    case (ch)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    #1;
  endtask

  task automatic idle(input int ch, input int n, input logic par);
    sh[ch] = 1'b0;
    en[ch] = 1'b0;
    for (int i = 0; i < n; i++) cyc(ch, mk(1'b0, 1'b0, 1'b0, par));
  endtask

  task automatic load_word(input int ch, input logic [31:0] word, input string seq, input logic par);
    en[ch] = 1'b1;
    sh[ch] = 1'b0;
    pdata  = word;
    cyc(ch, mk(sbit(seq, 0), 1'b1, 1'b0, par));
    en[ch] = 1'b0;
    pdata  = ~word;  // must not disturb the word in flight
  endtask

  // Advance through bits 1..N-1; shift_en is high on every period-th edge.
  task automatic shift_bits(input int ch, input string seq, input int period,
                            input logic par, input bit junk);
    for (int k = 1; k < seq.len(); k++) begin
      for (int p = 1; p <= period; p++) begin
        sh[ch] = (p == period);
        en[ch] = junk && (k == 3);
        if (junk) pdata = 32'h3C;
        cyc(ch, mk((p == period) ? sbit(seq, k) : sbit(seq, k - 1), 1'b1, 1'b0, par));
      end
    end
    en[ch] = 1'b0;
    sh[ch] = 1'b0;
  endtask

  task automatic finish_word(input int ch, input string seq, input int period, input logic par,
                             input bit reload, input logic [31:0] rword, input string rseq,
                             input logic rpar);
    for (int p = 1; p < period; p++) begin
      sh[ch] = 1'b0;
      cyc(ch, mk(sbit(seq, seq.len() - 1), 1'b1, 1'b0, par));
    end
    sh[ch] = 1'b1;
    en[ch] = reload;
    pdata  = rword;
    if (reload) cyc(ch, mk(sbit(rseq, 0), 1'b1, 1'b1, rpar));
    else        cyc(ch, mk(1'b0, 1'b0, 1'b1, par));
    sh[ch] = 1'b0;
    en[ch] = 1'b0;
  endtask

  initial begin
    rst   = 3'b000;
    en    = 3'b111;
    sh    = 3'b000;
    pdata = 32'hFFFF_FFFF;

    // Reset held two edges with a load request pending.
    cyc(0, mk(1'b0, 1'b0, 1'b0, 1'b0));
    cyc(0, mk(1'b0, 1'b0, 1'b0, 1'b0));
    rst = 3'b111;
    en  = 3'b000;
    idle(0, 2, 1'b0);

    // LSB-first 8'b10110011, shift_en held high.
    load_word(0, 32'hB3, "11001101", 1'b1);
    shift_bits(0, "11001101", 1, 1'b1, 1'b0);
    finish_word(0, "11001101", 1, 1'b1, 1'b0, 32'h0, "0", 1'b0);
    idle(0, 2, 1'b1);

    // MSB-first instance, same word.
    idle(1, 1, 1'b0);
    load_word(1, 32'hB3, "10110011", 1'b1);
    shift_bits(1, "10110011", 1, 1'b1, 1'b0);
    finish_word(1, "10110011", 1, 1'b1, 1'b0, 32'h0, "0", 1'b0);
    idle(1, 2, 1'b1);

    // Stalled shifting: one tick every 4 cycles, 8'hA5.
    load_word(0, 32'hA5, "10100101", 1'b0);
    shift_bits(0, "10100101", 4, 1'b0, 1'b0);
    finish_word(0, "10100101", 4, 1'b0, 1'b0, 32'h0, "0", 1'b0);
    idle(0, 2, 1'b0);

    // Mid-word load ignored, then back-to-back reload of 8'h3C.
    load_word(0, 32'hB3, "11001101", 1'b1);
    shift_bits(0, "11001101", 1, 1'b1, 1'b1);
    finish_word(0, "11001101", 1, 1'b1, 1'b0, 32'h0, "0", 1'b0);
    load_word(0, 32'hA5, "10100101", 1'b0);
    shift_bits(0, "10100101", 1, 1'b0, 1'b1);
    finish_word(0, "10100101", 1, 1'b0, 1'b1, 32'h3C, "00111100", 1'b0);
    shift_bits(0, "00111100", 1, 1'b0, 1'b0);
    finish_word(0, "00111100", 1, 1'b0, 1'b0, 32'h0, "0", 1'b0);
    idle(0, 2, 1'b0);

    // Reset after bit 3 aborts the word with no ser_done.
    load_word(0, 32'hB3, "11001101", 1'b1);
    sh[0] = 1'b1;
    cyc(0, mk(1'b1, 1'b1, 1'b0, 1'b1));
    cyc(0, mk(1'b0, 1'b1, 1'b0, 1'b1));
    cyc(0, mk(1'b0, 1'b1, 1'b0, 1'b1));
    rst[0] = 1'b0;
    cyc(0, mk(1'b0, 1'b0, 1'b0, 1'b0));
    rst[0] = 1'b1;
    idle(0, 12, 1'b0);

    // 12-bit instance, 12'hF0F LSB-first.
    idle(2, 1, 1'b0);
    load_word(2, 32'hF0F, "111100001111", 1'b0);
    shift_bits(2, "111100001111", 1, 1'b0, 1'b0);
    finish_word(2, "111100001111", 1, 1'b0, 1'b0, 32'h0, "0", 1'b0);
    idle(2, 2, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size() + q2.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_serializer.md
Name: param_serializer

Overview:
Parametrised parallel-to-serial converter for the UART TX datapath. It is the successor of the fixed 8-bit serializer, generalised in data width and bit order. It adds a shift-enable (baud tick) input to stall shifting, a busy flag, back-to-back loading on the completion edge, and a registered even-parity bit of the loaded word for the downstream parity stage.

Parameters:
DATA_WIDTH, 8, bits per word; legal range 2..32.
MSB_FIRST, 0, bit order: 0 = LSB first, 1 = MSB first.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous active-low reset, sampled on rising edge of CLK.
P_DATA  input  DATA_WIDTH  parallel word; sampled only on a load edge.
ser_en  input  1  load strobe; level sampled at each edge.
shift_en  input  1  advance enable (baud tick); when 0 the serializer holds.
ser_data  output  1  registered serial bit.
ser_done  output  1  one-cycle pulse after the last bit period.
busy  output  1  high while a word is being shifted.
par_bit  output  1  XOR of the loaded word (even-parity bit); held until the next load.

Behaviour:
- Reset: when RST=0 at an edge, all state clears. ser_data=0, ser_done=0, busy=0, par_bit=0, counter=0, FSM=IDLE. Reset takes priority over every other input.
- FSM has two states, IDLE and SHIFT. The counter width is clog2(DATA_WIDTH).
- Load edge: the FSM is in IDLE, ser_en=1 and RST=1. On that edge:
  - shift_reg captures P_DATA.
  - ser_data takes bit 0 (LSB) if MSB_FIRST=0, or bit DATA_WIDTH-1 if MSB_FIRST=1.
  - counter becomes 0, busy becomes 1, FSM moves to SHIFT.
  - par_bit takes ^P_DATA.
  - shift_en is don't-care on a load edge.
- Advancing edge: the FSM is in SHIFT and shift_en=1.
  - If counter < DATA_WIDTH-1: counter increments and ser_data presents the next bit in the selected order.
  - If counter = DATA_WIDTH-1 (completion edge): ser_done becomes 1 for exactly one cycle. With no reload, busy and ser_data become 0 and the FSM returns to IDLE.
- Stall: in SHIFT with shift_en=0, all state holds. ser_done stays 0.
- Timing with shift_en held at 1: for a load at edge E0, bit k is on ser_data in the cycle after edge Ek, for k = 0..DATA_WIDTH-1. ser_done is high in the cycle after edge E_DATA_WIDTH.
- ser_en while busy is ignored, except on the completion edge.
- Back-to-back: if ser_en=1 on the completion edge, the new word loads on that same edge.
  - ser_done still pulses.
  - busy stays 1.
  - ser_data takes the new word's first bit.
  - par_bit updates.
  - This gives no idle gap between words.
- ser_done is 0 in every cycle other than the one after a completion edge.
- Reset mid-word aborts the word. No ser_done is produced and outputs take their reset values.
- P_DATA may change freely after the load edge without affecting the output.

Test Plan:
1. Reset: hold RST=0 for 2 edges with ser_en=1 and P_DATA=8'hFF -> ser_data=0, busy=0, ser_done=0, par_bit=0.
2. LSB-first, DATA_WIDTH=8, shift_en=1, load 8'b10110011 -> ser_data sequence 1,1,0,0,1,1,0,1. busy high for 8 cycles, ser_done pulses in the 9th cycle after load, par_bit=1.
3. MSB_FIRST=1 instance, same word -> ser_data 1,0,1,1,0,0,1,1. ser_done timing and par_bit=1 unchanged.
4. Stall: shift_en pulsed 1 every 4th cycle, load 8'hA5 -> each bit is held 4 cycles. ser_done occurs on the 8th tick after load, not before; par_bit=0.
5. Back-to-back and busy rejection:
   - Pulse ser_en with 8'h3C mid-word -> ignored.
   - Assert ser_en with 8'h3C on the completion edge of 8'hA5 -> ser_done pulses, busy stays 1, and 0,0,1,1,1,1,0,0 follows with no gap.
6. Reset mid-word, and width check: drive RST=0 after bit 3 -> next cycle busy=0 and ser_data=0, with no ser_done ever. Then a DATA_WIDTH=12 instance loading 12'hF0F LSB-first -> 1,1,1,1,0,0,0,0,1,1,1,1, ser_done after 12 bits, par_bit=0.
